// File: rtl/button_debouncer_pkg.sv
// Shared alarm-clock types and default timing constants (100 MHz system clock).
// Used by the button debouncer, edge detectors and clock-keeping blocks.
package alarm_clock_pkg;

  typedef enum logic [1:0] {DB_LO, DB_WAIT_HI, DB_HI, DB_WAIT_LO} db_state_t;

  localparam int DEF_NUM_BTN       = 5;
  localparam int DEF_STABLE_CYCLES = 1_000_000;
  localparam int DEF_LONG_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;

  // Counter width helper that never collapses to a zero-width vector.
  function automatic int min1_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One button: 2-FF synchroniser, four-state debounce FSM and, when
// BTN_DEBOUNCE_LONG_PRESS_EN is defined, long-press auto-repeat pulses.
module debounce_channel
  import alarm_clock_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_db,
  output logic o_rep
);

  localparam int CNT_W = min1_clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // The repeat reload and the debounce counter both assume these relationships.
  if (!((STABLE_CYCLES > 1) && (REPEAT_CYCLES > 0) && (LONG_CYCLES > REPEAT_CYCLES))) begin : g_cfg_check
    $error("debounce_channel: invalid timing parameters");
  end

  logic             r_sync1;
  logic             r_sync2;
  db_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A WAIT state only commits after STABLE_CYCLES agreeing samples in a row.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= DB_LO;
      r_cnt   <= '0;
      r_db    <= 1'b0;
    end else begin
      unique case (r_state)
        DB_LO: begin
          if (r_sync2) begin
            r_state <= DB_WAIT_HI;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        DB_WAIT_HI: begin
          if (!r_sync2) begin
            r_state <= DB_LO;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= DB_HI;
            r_cnt   <= '0;
            r_db    <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        DB_HI: begin
          if (!r_sync2) begin
            r_state <= DB_WAIT_LO;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        DB_WAIT_LO: begin
          if (r_sync2) begin
            r_state <= DB_HI;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= DB_LO;
            r_cnt   <= '0;
            r_db    <= 1'b0;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign o_db = r_db;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int HOLD_W = min1_clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(LONG_CYCLES - REPEAT_CYCLES);

  logic [HOLD_W-1:0] r_hold;
  logic              r_rep;

  // Only a clean HI counts; any glitch into WAIT_LO restarts long-press timing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold <= '0;
      r_rep  <= 1'b0;
    end else if (r_state == DB_HI) begin
      if (r_hold == HOLD_LAST) begin
        r_hold <= HOLD_RELOAD;
        r_rep  <= 1'b1;
      end else begin
        r_hold <= r_hold + HOLD_ONE;
        r_rep  <= 1'b0;
      end
    end else begin
      r_hold <= '0;
      r_rep  <= 1'b0;
    end
  end

  assign o_rep = r_rep;
`else
  assign o_rep = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BTN asynchronous push buttons into clean clk-domain levels.
// Long-press auto-repeat pulses on btn_rep exist only with BTN_DEBOUNCE_LONG_PRESS_EN.
module button_debouncer
  import alarm_clock_pkg::*;
#(
  parameter int NUM_BTN       = DEF_NUM_BTN,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_db,
  output logic [NUM_BTN-1:0] btn_rep
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .i_clk (clk),
      .i_rst (rst),
      .i_raw (btn_raw[i]),
      .o_db  (btn_db[i]),
      .o_rep (btn_rep[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed vectors plus random presses
// compared against a run-length reference model of the debounce rules.
module tb_button_debouncer;

  localparam int NB = 5;
  localparam int ST = 4;
  localparam int LG = 20;
  localparam int RP = 8;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btnRaw = '0;
  logic [NB-1:0] btnDb;
  logic [NB-1:0] btnRep;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .NUM_BTN       (NB),
    .STABLE_CYCLES (ST),
    .LONG_CYCLES   (LG),
    .REPEAT_CYCLES (RP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btnRaw),
    .btn_db  (btnDb),
    .btn_rep (btnRep)
  );

  // Reference model: a level flips once the synchronised input has disagreed with
  // it for ST consecutive samples; repeats fire at clean-high hold counts LG, LG+RP, ...
  bit mSyncA [NB];
  bit mSyncB [NB];
  bit mDb    [NB];
  bit mRep   [NB];
  int mRun   [NB];
  int mHeld  [NB];
  logic [NB-1:0] modelDbVec;
  logic [NB-1:0] modelRepVec;

  task automatic modelStep(input logic r, input logic [NB-1:0] raw);
    bit s;
    bit cleanHi;
    for (int i = 0; i < NB; i++) begin
      if (r) begin
        mSyncA[i] = 0; mSyncB[i] = 0; mDb[i] = 0; mRep[i] = 0;
        mRun[i] = 0; mHeld[i] = 0;
      end else begin
        s = mSyncB[i];
        mSyncB[i] = mSyncA[i];
        mSyncA[i] = raw[i];
        cleanHi = mDb[i] && (mRun[i] == 0);
        if (cleanHi) mHeld[i]++;
        else mHeld[i] = 0;
        mRep[i] = REP_EN && cleanHi && (mHeld[i] >= LG) && (((mHeld[i] - LG) % RP) == 0);
        if (s != mDb[i]) begin
          mRun[i]++;
          if (mRun[i] == ST) begin
            mDb[i]  = s;
            mRun[i] = 0;
          end
        end else begin
          mRun[i] = 0;
        end
      end
      modelDbVec[i]  = mDb[i];
      modelRepVec[i] = mRep[i];
    end
  endtask

  task automatic checkOutput(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // One clock: drive before the edge, advance the model at the edge, sample mid-cycle.
  task automatic applyStimulus(input logic r, input logic [NB-1:0] raw);
    rst    = r;
    btnRaw = raw;
    @(posedge clk);
    modelStep(r, raw);
    @(negedge clk);
    checkOutput("model_db", btnDb, modelDbVec);
    checkOutput("model_rep", btnRep, modelRepVec);
  endtask

  typedef struct {
    logic          rst;
    logic [NB-1:0] raw;
    logic [NB-1:0] expDb;
    logic [NB-1:0] expRep;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input logic r, input logic [NB-1:0] raw, input logic [NB-1:0] db);
    vec_t v;
    v.rst = r; v.raw = raw; v.expDb = db; v.expRep = '0;
    return v;
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    logic [NB-1:0] raw;
    bit            bounce [10];
    bit            release0 [10];
    int            den;
    int            k;

    // Reset, clean press on bit 0, and a 3-cycle glitch on bit 2.
    for (int i = 0; i < 2; i++) vecs.push_back(mkVec(1'b1, 5'b00000, 5'b00000));
    for (int i = 0; i < 5; i++) vecs.push_back(mkVec(1'b0, 5'b00001, 5'b00000));
    for (int i = 0; i < 2; i++) vecs.push_back(mkVec(1'b0, 5'b00001, 5'b00001));
    for (int i = 0; i < 3; i++) vecs.push_back(mkVec(1'b0, 5'b00101, 5'b00001));
    for (int i = 0; i < 8; i++) vecs.push_back(mkVec(1'b0, 5'b00001, 5'b00001));

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].raw);
      checkOutput($sformatf("vec%0d_db", i), btnDb, vecs[i].expDb);
      checkOutput($sformatf("vec%0d_rep", i), btnRep, vecs[i].expRep);
    end
    raw = 5'b00001;

    // Press bounce on bit 1; the final 0->1 is step 4.
    bounce = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 12; i++) begin
      raw[1] = (i < 10) ? bounce[i] : 1'b1;
      applyStimulus(1'b0, raw);
      checkOutput($sformatf("bounce%0d_db1", i), NB'(btnDb[1]), NB'(i >= 9));
    end

    // Release bounce on bit 0; the final fall is step 3.
    release0 = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      raw[0] = release0[i];
      applyStimulus(1'b0, raw);
      checkOutput($sformatf("release%0d_db0", i), NB'(btnDb[0]), NB'(i < 8));
    end

    // Long press on bit 3: held 56 cycles past the debounced rise, then released.
    raw[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, raw);
      checkOutput($sformatf("long_rise%0d_db3", i), NB'(btnDb[3]), NB'(i == 5));
    end
    for (k = 1; k <= 80; k++) begin
      raw[3] = (k <= 56);
      applyStimulus(1'b0, raw);
      checkOutput($sformatf("long_hold%0d_rep3", k), NB'(btnRep[3]),
                  NB'(REP_EN && (k >= 20) && (k <= 52) && (((k - 20) % 8) == 0)));
    end

    // Reset while bit 4 sits in WAIT_HI with two samples counted; bit 1 is high.
    raw[4] = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, raw);
    applyStimulus(1'b1, raw);
    checkOutput("rst_mid_wait_db", btnDb, 5'b00000);
    checkOutput("rst_mid_wait_rep", btnRep, 5'b00000);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, raw);
      checkOutput($sformatf("post_rst%0d_db", i), btnDb, (i == 5) ? 5'b10010 : 5'b00000);
    end

    // Random phase alternating choppy and calm regimes, with rare resets.
    den = 3;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 150) == 0) den = ($urandom_range(0, 1) == 0) ? 3 : 40;
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, den - 1) == 0) raw[b] = ~raw[b];
      applyStimulus(($urandom_range(0, 499) == 0), raw);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
